// File: rtl/soc_sram_responder.sv
// Responder end of the core's instruction/data SRAM interface: shared word RAM,
// MMIO register window on the data port, and illegal-access flagging/counting.
module soc_sram_responder #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [31:0] RAM_BASE  = 32'h1c00_0000,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic        err,
  output logic [15:0] err_cnt
);

  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_NUM    = 16'hf010;
  localparam logic [15:0] OFF_TIMER  = 16'he000;
  localparam logic [15:0] OFF_SWITCH = 16'hf020;

  logic [31:0] r_mem [DEPTH];

  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic [15:0] r_led;
  logic [31:0] r_num;
  logic [31:0] r_timer;
  logic        r_err;
  logic [15:0] r_err_cnt;

  logic [ADDR_W-1:0] w_inst_idx;
  logic [ADDR_W-1:0] w_data_idx;
  logic              w_inst_ram_hit;
  logic              w_data_ram_hit;
  logic              w_data_mmio_hit;
  logic [15:0]       w_off;
  logic              w_sel_led;
  logic              w_sel_num;
  logic              w_sel_timer;
  logic              w_sel_switch;
  logic              w_data_legal;
  logic              w_inst_err;
  logic              w_data_err;
  logic [31:0]       w_mmio_rdata;
  logic [16:0]       w_err_cnt_sum;
  logic [15:0]       w_err_cnt_next;
  logic              w_unused;

  // Address decode; byte-lane bits [1:0] never participate.
  assign w_inst_idx      = inst_sram_addr[ADDR_W+1:2];
  assign w_data_idx      = data_sram_addr[ADDR_W+1:2];
  assign w_inst_ram_hit  = (inst_sram_addr[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2]);
  assign w_data_ram_hit  = (data_sram_addr[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2]);
  assign w_data_mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign w_off           = {data_sram_addr[15:2], 2'b00};
  assign w_unused        = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

  assign w_sel_led    = w_data_mmio_hit && (w_off == OFF_LED);
  assign w_sel_num    = w_data_mmio_hit && (w_off == OFF_NUM);
  assign w_sel_timer  = w_data_mmio_hit && (w_off == OFF_TIMER);
  assign w_sel_switch = w_data_mmio_hit && (w_off == OFF_SWITCH);

  // SWITCH is read-only, so a write to it is as illegal as an unmapped address.
  assign w_data_legal = w_data_ram_hit || w_sel_led || w_sel_num || w_sel_timer ||
                        (w_sel_switch && !data_sram_we);
  assign w_inst_err   = !w_inst_ram_hit;
  assign w_data_err   = !w_data_legal;

  always_comb begin
    w_mmio_rdata = 32'h0;
    if (w_sel_led)    w_mmio_rdata = {16'h0, r_led};
    if (w_sel_num)    w_mmio_rdata = r_num;
    if (w_sel_timer)  w_mmio_rdata = r_timer;
    if (w_sel_switch) w_mmio_rdata = {16'h0, sw};
  end

  // Both ports can be illegal in one cycle; clamp at all-ones.
  assign w_err_cnt_sum  = {1'b0, r_err_cnt} + 17'(w_inst_err) + 17'(w_data_err);
  assign w_err_cnt_next = w_err_cnt_sum[16] ? 16'hffff : w_err_cnt_sum[15:0];

  // RAM array is not reset; data port is written last so it wins a same-word clash.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (inst_sram_we && w_inst_ram_hit) r_mem[w_inst_idx] <= inst_sram_wdata;
      if (data_sram_we && w_data_ram_hit) r_mem[w_data_idx] <= data_sram_wdata;
    end
  end

  // Read data and MMIO registers; reads see pre-edge contents (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
      r_led        <= 16'h0;
      r_num        <= 32'h0;
      r_timer      <= 32'h0;
      r_err        <= 1'b0;
      r_err_cnt    <= 16'h0;
    end else begin
      r_inst_rdata <= w_inst_err ? 32'h0 : r_mem[w_inst_idx];
      if (w_data_err)          r_data_rdata <= 32'h0;
      else if (w_data_ram_hit) r_data_rdata <= r_mem[w_data_idx];
      else                     r_data_rdata <= w_mmio_rdata;
      r_err     <= w_inst_err || w_data_err;
      r_err_cnt <= w_err_cnt_next;
      if (data_sram_we && w_sel_led) r_led <= data_sram_wdata[15:0];
      if (data_sram_we && w_sel_num) r_num <= data_sram_wdata;
      if (data_sram_we && w_sel_timer) r_timer <= data_sram_wdata;
      else                             r_timer <= r_timer + 32'd1;
    end
  end

  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;
  assign led             = r_led;
  assign num             = r_num;
  assign err             = r_err;
  assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_soc_sram_responder.sv
// Self-checking bench for soc_sram_responder: directed scenarios plus randomized
// traffic compared against an address-range/array reference model.
module tb_soc_sram_responder;

  localparam logic [31:0] RAM_BASE  = 32'h1c00_0000;
  localparam logic [31:0] RAM_BYTES = 32'h0004_0000;
  localparam logic [31:0] A_LED     = 32'hbfaf_f000;
  localparam logic [31:0] A_NUM     = 32'hbfaf_f010;
  localparam logic [31:0] A_TIMER   = 32'hbfaf_e000;
  localparam logic [31:0] A_SWITCH  = 32'hbfaf_f020;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [15:0] sw, led, err_cnt;
  logic [31:0] num;
  logic        err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_num, m_timer;
  logic [15:0] m_cnt;
  logic [31:0] e_ird, e_drd;
  logic        e_err;

  logic [31:0] pool [10];

  soc_sram_responder dut (
    .clk(clk), .reset(reset),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .sw(sw), .led(led), .num(num), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mrd(int idx);
    if (m_mem.exists(idx)) return m_mem[idx];
    return 32'h0;
  endfunction

  function automatic bit in_ram(logic [31:0] a);
    return (a >= RAM_BASE) && (a < RAM_BASE + RAM_BYTES);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] dw;
    logic [31:0] dread;
    bit i_ok, d_ok;
    int ii, di, s;
    if (reset) begin
      e_ird = 0; e_drd = 0; e_err = 0;
      m_led = 0; m_num = 0; m_timer = 0; m_cnt = 0;
    end else begin
      dw    = data_sram_addr & 32'hffff_fffc;
      i_ok  = in_ram(inst_sram_addr);
      ii    = int'((inst_sram_addr - RAM_BASE) >> 2);
      di    = int'((data_sram_addr - RAM_BASE) >> 2);
      d_ok  = 1;
      dread = 0;
      if (in_ram(data_sram_addr)) dread = mrd(di);
      else if (dw == A_LED)       dread = {16'h0, m_led};
      else if (dw == A_NUM)       dread = m_num;
      else if (dw == A_TIMER)     dread = m_timer;
      else if (dw == A_SWITCH && !data_sram_we) dread = {16'h0, sw};
      else                        d_ok = 0;
      e_ird = i_ok ? mrd(ii) : 32'h0;
      e_drd = d_ok ? dread : 32'h0;
      e_err = !i_ok || !d_ok;
      s = int'(m_cnt) + (i_ok ? 0 : 1) + (d_ok ? 0 : 1);
      if (s > 65535) s = 65535;
      m_cnt = 16'(s);
      if (inst_sram_we && i_ok) m_mem[ii] = inst_sram_wdata;
      if (data_sram_we && in_ram(data_sram_addr)) m_mem[di] = data_sram_wdata;
      if (data_sram_we && dw == A_LED) m_led = data_sram_wdata[15:0];
      if (data_sram_we && dw == A_NUM) m_num = data_sram_wdata;
      if (data_sram_we && dw == A_TIMER) m_timer = data_sram_wdata;
      else m_timer = m_timer + 32'd1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_we = 0; inst_sram_addr = RAM_BASE; inst_sram_wdata = 0;
    data_sram_we = 0; data_sram_addr = RAM_BASE; data_sram_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); sw = 16'h0;
    tick(); tick();
    total += 6;
    if (inst_sram_rdata !== 32'h0) begin bad++; $display("FAIL reset_irdata got=%h exp=0", inst_sram_rdata); end
    if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL reset_drdata got=%h exp=0", data_sram_rdata); end
    if (led !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=0", led); end
    if (num !== 32'h0) begin bad++; $display("FAIL reset_num got=%h exp=0", num); end
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    if (err_cnt !== 16'h0) begin bad++; $display("FAIL reset_errcnt got=%h exp=0", err_cnt); end
    reset = 0;
  endtask

  task automatic preload();
    for (int k = 0; k < 8; k++) pool[k] = RAM_BASE + 32'(k * 4);
    pool[8] = RAM_BASE + 32'h100;
    pool[9] = RAM_BASE + RAM_BYTES - 32'd4;
    for (int k = 0; k < 10; k++) begin
      data_sram_we = 1; data_sram_addr = pool[k]; data_sram_wdata = $urandom;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_store_load();
    data_sram_we = 1; data_sram_addr = 32'h1c00_0100; data_sram_wdata = 32'hdead_beef;
    tick();
    data_sram_we = 0; inst_sram_addr = 32'h1c00_0100;
    tick();
    total += 3;
    if (data_sram_rdata !== 32'hdead_beef) begin bad++; $display("FAIL store_load_data got=%h exp=deadbeef", data_sram_rdata); end
    if (inst_sram_rdata !== 32'hdead_beef) begin bad++; $display("FAIL store_load_inst got=%h exp=deadbeef", inst_sram_rdata); end
    if (err !== 1'b0) begin bad++; $display("FAIL store_load_err got=%b exp=0", err); end
    data_sram_addr = 32'h1c00_0103;
    tick();
    total++;
    if (data_sram_rdata !== 32'hdead_beef) begin bad++; $display("FAIL lowbits_ignored got=%h exp=deadbeef", data_sram_rdata); end
    idle();
  endtask

  task automatic test_collision();
    data_sram_we = 1; data_sram_addr = 32'h1c00_0200; data_sram_wdata = 32'h1111_1111;
    tick();
    data_sram_wdata = 32'h2222_2222; inst_sram_addr = 32'h1c00_0200;
    tick();
    total += 2;
    if (inst_sram_rdata !== 32'h1111_1111) begin bad++; $display("FAIL collide_inst_old got=%h exp=11111111", inst_sram_rdata); end
    if (data_sram_rdata !== 32'h1111_1111) begin bad++; $display("FAIL collide_data_old got=%h exp=11111111", data_sram_rdata); end
    data_sram_we = 0;
    tick();
    total++;
    if (inst_sram_rdata !== 32'h2222_2222) begin bad++; $display("FAIL collide_reread got=%h exp=22222222", inst_sram_rdata); end
    inst_sram_we = 1; inst_sram_wdata = 32'haaaa_aaaa;
    data_sram_we = 1; data_sram_wdata = 32'hbbbb_bbbb;
    tick();
    inst_sram_we = 0; data_sram_we = 0;
    tick();
    total++;
    if (inst_sram_rdata !== 32'hbbbb_bbbb) begin bad++; $display("FAIL dual_write_data_wins got=%h exp=bbbbbbbb", inst_sram_rdata); end
    idle();
  endtask

  task automatic test_mmio();
    data_sram_we = 1; data_sram_addr = A_LED; data_sram_wdata = 32'h0001_abcd;
    tick();
    total++;
    if (led !== 16'habcd) begin bad++; $display("FAIL led_write got=%h exp=abcd", led); end
    data_sram_we = 0;
    tick();
    total++;
    if (data_sram_rdata !== 32'h0000_abcd) begin bad++; $display("FAIL led_read got=%h exp=0000abcd", data_sram_rdata); end
    data_sram_we = 1; data_sram_addr = A_NUM; data_sram_wdata = 32'h1234_5678;
    tick();
    total++;
    if (num !== 32'h1234_5678) begin bad++; $display("FAIL num_write got=%h exp=12345678", num); end
    data_sram_we = 0; data_sram_addr = A_SWITCH; sw = 16'h5a5a;
    tick();
    total++;
    if (data_sram_rdata !== 32'h0000_5a5a) begin bad++; $display("FAIL switch_read got=%h exp=00005a5a", data_sram_rdata); end
    idle();
  endtask

  task automatic test_timer();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'hffff_fffe; exp_seq[1] = 32'hffff_ffff;
    exp_seq[2] = 32'h0000_0000; exp_seq[3] = 32'h0000_0001;
    data_sram_we = 1; data_sram_addr = A_TIMER; data_sram_wdata = 32'hffff_fffe;
    tick();
    data_sram_we = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (data_sram_rdata !== exp_seq[k]) begin bad++; $display("FAIL timer_seq%0d got=%h exp=%h", k, data_sram_rdata, exp_seq[k]); end
    end
    data_sram_we = 1; data_sram_wdata = 32'h0000_0100;
    tick();
    total++;
    if (data_sram_rdata !== 32'h2) begin bad++; $display("FAIL timer_read_at_write got=%h exp=2", data_sram_rdata); end
    data_sram_we = 0;
    tick();
    total++;
    if (data_sram_rdata !== 32'h0000_0100) begin bad++; $display("FAIL timer_write_wins got=%h exp=100", data_sram_rdata); end
    idle();
  endtask

  task automatic test_illegal();
    data_sram_addr = 32'h0000_0000;
    tick();
    total += 3;
    if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL illegal_rdata got=%h exp=0", data_sram_rdata); end
    if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", err); end
    if (err_cnt !== 16'd1) begin bad++; $display("FAIL illegal_cnt1 got=%0d exp=1", err_cnt); end
    idle();
    tick();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b exp=0", err); end
    inst_sram_addr = A_LED;
    data_sram_we = 1; data_sram_addr = A_SWITCH; data_sram_wdata = 32'h0000_ffff;
    tick();
    total += 3;
    if (err_cnt !== 16'd3) begin bad++; $display("FAIL illegal_cnt3 got=%0d exp=3", err_cnt); end
    if (inst_sram_rdata !== 32'h0) begin bad++; $display("FAIL inst_mmio_rdata got=%h exp=0", inst_sram_rdata); end
    if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL switch_write_rdata got=%h exp=0", data_sram_rdata); end
    idle(); data_sram_addr = A_SWITCH;
    tick();
    total++;
    if (data_sram_rdata !== 32'h0000_5a5a) begin bad++; $display("FAIL switch_unchanged got=%h exp=00005a5a", data_sram_rdata); end
    data_sram_addr = 32'hbfaf_f030;
    tick();
    total++;
    if (err_cnt !== 16'd4) begin bad++; $display("FAIL unmapped_mmio got=%0d exp=4", err_cnt); end
    idle();
  endtask

  task automatic test_random();
    int c;
    for (int n = 0; n < 400; n++) begin
      inst_sram_we = ($urandom_range(0, 3) == 0);
      inst_sram_wdata = $urandom;
      inst_sram_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                       : (pool[$urandom_range(0, 9)] | 32'($urandom_range(0, 3)));
      data_sram_we = ($urandom_range(0, 2) == 0);
      data_sram_wdata = $urandom;
      c = $urandom_range(0, 10);
      case (c)
        6:       data_sram_addr = A_LED;
        7:       data_sram_addr = A_NUM;
        8:       data_sram_addr = A_TIMER;
        9:       data_sram_addr = A_SWITCH;
        10:      data_sram_addr = 32'($urandom);
        default: data_sram_addr = pool[$urandom_range(0, 9)];
      endcase
      data_sram_addr = data_sram_addr | 32'($urandom_range(0, 3));
      sw = 16'($urandom);
      tick();
      total += 6;
      if (inst_sram_rdata !== e_ird) begin bad++; $display("FAIL rnd%0d_irdata got=%h exp=%h", n, inst_sram_rdata, e_ird); end
      if (data_sram_rdata !== e_drd) begin bad++; $display("FAIL rnd%0d_drdata got=%h exp=%h", n, data_sram_rdata, e_drd); end
      if (err !== e_err) begin bad++; $display("FAIL rnd%0d_err got=%b exp=%b", n, err, e_err); end
      if (err_cnt !== m_cnt) begin bad++; $display("FAIL rnd%0d_errcnt got=%h exp=%h", n, err_cnt, m_cnt); end
      if (led !== m_led) begin bad++; $display("FAIL rnd%0d_led got=%h exp=%h", n, led, m_led); end
      if (num !== m_num) begin bad++; $display("FAIL rnd%0d_num got=%h exp=%h", n, num, m_num); end
    end
    idle();
  endtask

  task automatic test_saturate();
    idle();
    inst_sram_addr = 32'h0000_0000; data_sram_addr = 32'h0000_0000;
    for (int n = 0; n < 33000; n++) tick();
    total += 2;
    if (err_cnt !== 16'hffff) begin bad++; $display("FAIL errcnt_saturate got=%h exp=ffff", err_cnt); end
    if (err !== 1'b1) begin bad++; $display("FAIL saturate_err got=%b exp=1", err); end
    tick();
    total++;
    if (err_cnt !== 16'hffff) begin bad++; $display("FAIL errcnt_hold got=%h exp=ffff", err_cnt); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    data_sram_we = 1; data_sram_addr = A_LED; data_sram_wdata = 32'h0000_00ff;
    tick();
    total++;
    if (led !== 16'h00ff) begin bad++; $display("FAIL mid_led_set got=%h exp=00ff", led); end
    reset = 1;
    data_sram_addr = A_NUM; data_sram_wdata = 32'hcafe_f00d;
    inst_sram_we = 1; inst_sram_addr = pool[3]; inst_sram_wdata = ~mrd(3);
    tick();
    total += 6;
    if (inst_sram_rdata !== 32'h0) begin bad++; $display("FAIL mid_irdata got=%h exp=0", inst_sram_rdata); end
    if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL mid_drdata got=%h exp=0", data_sram_rdata); end
    if (led !== 16'h0) begin bad++; $display("FAIL mid_led got=%h exp=0", led); end
    if (num !== 32'h0) begin bad++; $display("FAIL mid_num got=%h exp=0", num); end
    if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", err); end
    if (err_cnt !== 16'h0) begin bad++; $display("FAIL mid_errcnt got=%h exp=0", err_cnt); end
    reset = 0; idle(); data_sram_addr = A_TIMER; inst_sram_addr = pool[3];
    tick();
    total += 3;
    if (data_sram_rdata !== 32'h0) begin bad++; $display("FAIL mid_timer0 got=%h exp=0", data_sram_rdata); end
    if (num !== 32'h0) begin bad++; $display("FAIL mid_num_dropped got=%h exp=0", num); end
    if (inst_sram_rdata !== e_ird) begin bad++; $display("FAIL mid_ram_write_dropped got=%h exp=%h", inst_sram_rdata, e_ird); end
    tick();
    total++;
    if (data_sram_rdata !== 32'h1) begin bad++; $display("FAIL mid_timer1 got=%h exp=1", data_sram_rdata); end
    idle();
  endtask

  initial begin
    test_reset();
    preload();
    test_store_load();
    test_collision();
    test_mmio();
    test_timer();
    test_illegal();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
